word_packer: RTL

Downstream consumer stage for the synchronous word FIFO. It drains FIFO words via the FIFO's `shift`/`empty`/`dout` interface, accounting for the FIFO's one-cycle registered read. It packs `PACK` consecutive words into one wide beat and presents that beat on a valid/ready output toward the next consumer. An assembly register and an output register are kept separate, so the next beat fills while the current one is stalled.

---
 rtl/word_packer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/word_packer.sv
// Packs PACK consecutive words from the registered-read FIFO into one wide valid/ready beat.
// Define WORD_PACKER_FLUSH_EN to compile in partial-beat flush support.
module word_packer #(
    parameter int DATAWIDTH = 16,
    parameter int PACK      = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      fifo_empty,
    input  logic [DATAWIDTH-1:0]      fifo_dout,
    output logic                      fifo_shift,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACK*DATAWIDTH-1:0] out_data,
    output logic [$clog2(PACK):0]     out_words
);

    localparam int CW = $clog2(PACK) + 1;
    localparam logic [CW-1:0] PACK_N = CW'(PACK);
    localparam logic [CW-1:0] ZERO_N = '0;

    if (PACK < 2) begin : g_pack_check
        $error("word_packer: PACK must be at least 2");
    end

    typedef enum logic {
        EMPTY,
        FULL
    } out_state_t;

    out_state_t state;
    out_state_t state_next;

    logic [CW-1:0]                    issued;
    logic [CW-1:0]                    recv;
    logic                             pop_d;
    logic                             flush_pend;
    logic [PACK-1:0][DATAWIDTH-1:0]   asm_lanes;

    logic pop;
    logic complete;
    logic drained;
    logic can_load;
    logic flush_load;
    logic load;

    always_comb begin
        fifo_shift = nRST & ~fifo_empty & (issued < PACK_N) & ~flush_pend;
        pop        = fifo_shift;
        complete   = (recv == PACK_N);
        drained    = (issued == recv);
        can_load   = ~out_valid | out_ready;
        // A pending flush may only emit once every issued pop has landed.
        flush_load = flush_pend & drained & (recv != ZERO_N);
        load       = (complete | flush_load) & can_load;
    end

`ifdef WORD_PACKER_FLUSH_EN
    logic flush_idle;

    always_comb begin
        flush_idle = flush_pend & drained & (recv == ZERO_N);
    end

    // Further flush requests while one is pending are absorbed.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            flush_pend <= 1'b0;
        end else if (flush_pend) begin
            if (flush_idle || (flush_load && can_load)) begin
                flush_pend <= 1'b0;
            end
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end
`else
    logic unused_flush;

    assign flush_pend   = 1'b0;
    assign unused_flush = flush;
`endif

    // The FIFO presents a popped word one cycle later, so landing follows pop_d.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            issued    <= '0;
            recv      <= '0;
            pop_d     <= 1'b0;
            asm_lanes <= '0;
        end else begin
            pop_d <= pop & ~fifo_empty;
            if (load) begin
                issued    <= '0;
                recv      <= '0;
                asm_lanes <= '0;
            end else begin
                if (pop) begin
                    issued <= issued + 1'b1;
                end
                if (pop_d) begin
                    recv <= recv + 1'b1;
                    for (int i = 0; i < PACK; i++) begin
                        if (recv == CW'(i)) begin
                            asm_lanes[i] <= fifo_dout;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_data  <= '0;
            out_words <= '0;
        end else if (load) begin
            out_data  <= asm_lanes;
            out_words <= recv;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Accepting a beat while loading another keeps the output register full.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (load) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready && !load) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

endmodule
